// File: rtl/seek_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// disc_pkg -- shared definitions for the seek sequencer slice.
//   seek_state_t : sequencer FSM state encoding
//   DIR_OUT/IN   : step-controller direction bit (1 = toward track 0)
//   MAX_CHUNK    : largest step count one control-byte write can carry
//   chunk_of()   : size of the next chunk for a given remaining-step count
// -----------------------------------------------------------------------------
package disc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE,
    ST_ACK,
    ST_WAIT,
    ST_CHECK,
    ST_SETTLE,
    ST_FINISH
  } seek_state_t;

  localparam logic       DIR_OUT   = 1'b1;
  localparam logic       DIR_IN    = 1'b0;
  localparam logic [8:0] MAX_CHUNK = 9'd128;

  function automatic logic [8:0] chunk_of(input logic [8:0] rem);
    return (rem > MAX_CHUNK) ? MAX_CHUNK : rem;
  endfunction

endpackage

// File: rtl/seek_sequencer_if.sv
// -----------------------------------------------------------------------------
// seek_sequencer_if -- host command/status and step-controller signals.
//   Host side   : cmd_start, cmd_recal, target_track -> busy, done, error,
//                 cur_track, track_valid
//   Step side   : step_ctlbyte, step_write -> step_busy, step_track0_hit
//   slave  modport: the sequencer
//   master modport: whatever drives commands and models the step controller
// -----------------------------------------------------------------------------
interface seek_sequencer_if;
  logic       cmd_start;
  logic       cmd_recal;
  logic [7:0] target_track;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] cur_track;
  logic       track_valid;
  logic [7:0] step_ctlbyte;
  logic       step_write;
  logic       step_busy;
  logic       step_track0_hit;

  modport slave (
    input  cmd_start, cmd_recal, target_track, step_busy, step_track0_hit,
    output busy, done, error, cur_track, track_valid, step_ctlbyte, step_write
  );

  modport master (
    output cmd_start, cmd_recal, target_track, step_busy, step_track0_hit,
    input  busy, done, error, cur_track, track_valid, step_ctlbyte, step_write
  );
endinterface

// File: rtl/seek_sequencer_settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer -- 16-bit load / count-down head-settle timer.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_load         : (re)start a delay of CYCLES clock cycles
//   o_done         : high during the last cycle of the delay (one-cycle pulse)
// -----------------------------------------------------------------------------
module settle_timer #(
  parameter logic [15:0] CYCLES = 16'd20000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  output logic o_done
);

  logic [15:0] r_cnt;
  logic        r_run;

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= 16'd0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= CYCLES;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt <= 16'd1) begin
        r_cnt <= 16'd0;
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 16'd1;
      end
    end
  end

  // The loaded cycle counts as the first one, so the delay spans exactly
  // CYCLES cycles (a zero load still yields a single cycle).
  assign o_done = r_run && (r_cnt <= 16'd1);

endmodule

// File: rtl/seek_sequencer.sv
// -----------------------------------------------------------------------------
// seek_sequencer -- seek / recalibrate engine in front of the head step
// controller. Tracks the head cylinder, splits each move into control-byte
// writes of at most 128 steps, interprets track-0 hits and applies a settle
// delay before reporting completion.
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus (slave)    : host command/status and step-controller handshake
//   SETTLE_CYCLES  : settle delay after a move
//   RECAL_STEPS    : outward step budget of a recalibrate (1..511)
// -----------------------------------------------------------------------------
module seek_sequencer
  import disc_pkg::*;
#(
  parameter logic [15:0] SETTLE_CYCLES = 16'd20000,
  parameter logic [8:0]  RECAL_STEPS   = 9'd256
) (
  input  logic              i_clk,
  input  logic              i_reset,
  seek_sequencer_if.slave   bus
);

  seek_state_t r_state, w_next_state;

  logic       r_recal;
  logic [7:0] r_target;
  logic       r_dir;
  logic [8:0] r_rem;
  logic       r_busy;
  logic       r_done;
  logic       r_error;
  logic [7:0] r_cur_track;
  logic       r_track_valid;

  logic       w_accept;
  logic [8:0] w_chunk;
  logic [8:0] w_rem_left;
  logic [6:0] w_count;
  logic       w_settle_done;
  logic       w_settle_load;
  logic       w_step_write;
  logic [7:0] w_step_ctlbyte;

  // A start that lands in the DONE cycle is dropped: r_done is still high.
  assign w_accept      = (r_state == ST_IDLE) && bus.cmd_start && !r_done;
  assign w_chunk       = chunk_of(r_rem);
  assign w_rem_left    = r_rem - w_chunk;
  // Count field N means N+1 pulses; a 128 chunk wraps cleanly to 7'h7F.
  assign w_count       = w_chunk[6:0] - 7'd1;
  assign w_settle_load = (r_state == ST_CHECK) && (w_next_state == ST_SETTLE);

  settle_timer #(.CYCLES(SETTLE_CYCLES)) u_settle (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_settle_load),
    .o_done  (w_settle_done)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first, so no path through the case leaves the signal
    // unassigned and a latch cannot be inferred.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next_state = ST_CALC;
      ST_CALC: begin
        if (r_recal)                        w_next_state = ST_ISSUE;
        else if (!r_track_valid)            w_next_state = ST_FINISH;
        else if (r_target == r_cur_track)   w_next_state = ST_FINISH;
        else                                w_next_state = ST_ISSUE;
      end
      ST_ISSUE:  w_next_state = ST_ACK;
      ST_ACK:    w_next_state = ST_WAIT;   // step_busy not yet meaningful
      ST_WAIT:   if (!bus.step_busy) w_next_state = ST_CHECK;
      ST_CHECK: begin
        if (bus.step_track0_hit)     w_next_state = ST_SETTLE;
        else if (w_rem_left != 9'd0) w_next_state = ST_ISSUE;
        else if (r_recal)            w_next_state = ST_FINISH; // never found 0
        else                         w_next_state = ST_SETTLE;
      end
      ST_SETTLE: if (w_settle_done) w_next_state = ST_FINISH;
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Moore outputs toward the step controller
  always_comb begin
    w_step_write   = 1'b0;
    w_step_ctlbyte = 8'h00;
    if (r_state == ST_ISSUE) begin
      w_step_write   = 1'b1;
      w_step_ctlbyte = {r_dir, w_count};
    end
  end

  // Command latch, position tracking and status registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_recal       <= 1'b0;
      r_target      <= 8'd0;
      r_dir         <= DIR_IN;
      r_rem         <= 9'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_cur_track   <= 8'd0;
      r_track_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_recal  <= bus.cmd_recal;
          r_target <= bus.target_track;
          r_error  <= 1'b0;
          r_busy   <= 1'b1;
        end
        ST_CALC: begin
          if (r_recal) begin
            r_dir         <= DIR_OUT;
            r_rem         <= RECAL_STEPS;
            r_track_valid <= 1'b0;
          end else if (!r_track_valid) begin
            r_error <= 1'b1;
          end else if (r_target < r_cur_track) begin
            r_dir <= DIR_OUT;
            r_rem <= {1'b0, r_cur_track} - {1'b0, r_target};
          end else begin
            r_dir <= DIR_IN;
            r_rem <= {1'b0, r_target} - {1'b0, r_cur_track};
          end
        end
        ST_CHECK: begin
          if (bus.step_track0_hit) begin
            r_cur_track <= 8'd0;
            if (r_recal)                r_track_valid <= 1'b1;
            else if (r_target != 8'd0)  r_error       <= 1'b1;
          end else begin
            r_rem <= w_rem_left;
            if (!r_recal)
              r_cur_track <= (r_dir == DIR_OUT) ? r_cur_track - w_chunk[7:0]
                                                : r_cur_track + w_chunk[7:0];
            else if (w_rem_left == 9'd0)
              r_error <= 1'b1;
          end
        end
        ST_FINISH: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.error        = r_error;
  assign bus.cur_track    = r_cur_track;
  assign bus.track_valid  = r_track_valid;
  assign bus.step_ctlbyte = w_step_ctlbyte;
  assign bus.step_write   = w_step_write;

endmodule

// File: tb/tb_seek_sequencer.sv
// -----------------------------------------------------------------------------
// tb_seek_sequencer -- self-checking bench for seek_sequencer.
// A behavioural drive + step-controller model answers control-byte writes;
// a reference model predicts, per command, the write bytes, final cylinder,
// validity, error flag and the cycle DONE appears in.
// -----------------------------------------------------------------------------
module tb_seek_sequencer;

  localparam logic [15:0] S     = 16'd20;
  localparam logic [8:0]  RECAL = 9'd256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seek_sequencer_if sif ();

  seek_sequencer #(.SETTLE_CYCLES(S), .RECAL_STEPS(RECAL)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (sif)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- drive + step controller model ----------------
  int         drive_pos;   // physical head cylinder
  bit         sensor_ok;   // track-0 sensor working
  bit         pend;
  logic [7:0] pend_byte;
  bit         cdir;
  int         left;
  int         last_fall;
  logic [7:0] got[$];

  always @(negedge clk) begin
    if (rst) begin
      sif.step_busy       = 1'b0;
      sif.step_track0_hit = 1'b0;
      pend = 0;
      left = 0;
    end else begin
      if (pend) begin
        pend = 0;
        sif.step_busy       = 1'b1;
        sif.step_track0_hit = 1'b0;
        cdir = pend_byte[7];
        left = int'(pend_byte[6:0]) + 1;
        if (cdir && sensor_ok && drive_pos == 0) left = 0;  // abort, no pulse
      end else if (sif.step_busy) begin
        if (left == 0) begin
          sif.step_busy       = 1'b0;
          sif.step_track0_hit = cdir && sensor_ok && (drive_pos == 0);
          last_fall = cyc;
        end else begin
          if (cdir) begin
            if (drive_pos > 0) drive_pos--;
          end else begin
            drive_pos++;
          end
          left--;
          if (cdir && sensor_ok && drive_pos == 0) left = 0;
        end
      end
      if (sif.step_write === 1'b1) begin
        pend      = 1;
        pend_byte = sif.step_ctlbyte;
        got.push_back(sif.step_ctlbyte);
      end
    end
  end

  // ---------------- reference model ----------------
  int         m_cur;
  bit         m_valid;
  logic [7:0] exp_q[$];
  int         e_cur;
  bit         e_valid;
  bit         e_err;
  int         e_kind;   // 0: no move, 1: move + settle, 2: failed recal

  task automatic model(input bit recal, input int target);
    int rem, chunk, p;
    bit out, hit;
    exp_q.delete();
    p = drive_pos; e_cur = m_cur; e_valid = m_valid; e_err = 0; e_kind = 0; hit = 0;
    if (recal) begin
      e_valid = 0;
      rem = int'(RECAL);
      while (rem > 0) begin
        chunk = (rem > 128) ? 128 : rem;
        exp_q.push_back({1'b1, 7'(chunk - 1)});
        if (sensor_ok && p <= chunk) begin hit = 1; break; end
        p = (p > chunk) ? p - chunk : 0;
        rem -= chunk;
      end
      if (hit) begin e_cur = 0; e_valid = 1; e_kind = 1; end
      else     begin e_err = 1; e_kind = 2; end
    end else if (!m_valid) begin
      e_err = 1;
    end else if (target != m_cur) begin
      out = (target < m_cur);
      rem = out ? m_cur - target : target - m_cur;
      e_kind = 1;
      while (rem > 0) begin
        chunk = (rem > 128) ? 128 : rem;
        exp_q.push_back({out, 7'(chunk - 1)});
        if (out && sensor_ok && p <= chunk) begin
          e_cur = 0; e_err = (target != 0); break;
        end
        if (out) p = (p > chunk) ? p - chunk : 0;
        else     p += chunk;
        e_cur = out ? e_cur - chunk : e_cur + chunk;
        rem -= chunk;
      end
    end
  endtask

  // ---------------- command runner ----------------
  task automatic run_op(input bit recal, input int target, input bit poke_at_done);
    int m, exp_cyc, n;
    bit seen;
    model(recal, target);
    got.delete();
    @(negedge clk);
    sif.cmd_start = 1'b1; sif.cmd_recal = recal; sif.target_track = target[7:0];
    m = cyc;
    @(negedge clk);
    sif.cmd_start = 1'b0;
    check("busy_after_start", sif.busy, 1);
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (sif.done === 1'b1) seen = 1;
      else @(negedge clk);
    end
    check("done_seen", seen, 1);
    if (seen) begin
      // No move: DONE in the 3rd cycle after the start edge.
      // Move: CHECK edge is 2 after the step_busy drop, DONE rises S+1 later.
      exp_cyc = (e_kind == 0) ? m + 3 : (e_kind == 1) ? last_fall + 3 + int'(S)
                                                       : last_fall + 3;
      check("done_cycle", cyc, exp_cyc);
      check("busy_at_done", sif.busy, 0);
      check("error", sif.error, e_err);
      check("track_valid", sif.track_valid, e_valid);
      check("cur_track", sif.cur_track, e_cur[7:0]);
      check("write_count", got.size(), exp_q.size());
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("ctlbyte[%0d]", i), got[i], exp_q[i]);
      if (poke_at_done) begin
        sif.cmd_start = 1'b1; sif.cmd_recal = 1'b1;
      end
      @(negedge clk);
      sif.cmd_start = 1'b0;
      check("done_one_cycle", sif.done, 0);
      if (poke_at_done) check("start_at_done_ignored", sif.busy, 0);
    end
    m_cur = e_cur; m_valid = e_valid;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r, t, dn;
    rst = 1'b1;
    sif.cmd_start = 1'b0; sif.cmd_recal = 1'b0; sif.target_track = 8'd0;
    sensor_ok = 1; drive_pos = 60; m_cur = 0; m_valid = 0; last_fall = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", sif.busy, 0);
    check("rst_done", sif.done, 0);
    check("rst_error", sif.error, 0);
    check("rst_cur_track", sif.cur_track, 0);
    check("rst_track_valid", sif.track_valid, 0);
    check("rst_ctlbyte", sif.step_ctlbyte, 0);
    check("rst_step_write", sif.step_write, 0);
    rst = 1'b0;

    run_op(0, 100, 0);               // seek with unknown position
    drive_pos = 37;
    run_op(1, 0, 0);                 // recal, track 0 after 37 steps
    run_op(0, 200, 0);               // 0x7F, 0x47
    run_op(0, 5, 0);                 // 0xFF, 0xC2
    run_op(0, 5, 1);                 // same track, start during DONE
    sensor_ok = 0;
    run_op(1, 0, 0);                 // track 0 never seen
    sensor_ok = 1;
    run_op(0, 9, 0);                 // position unknown again
    run_op(1, 0, 0);                 // already at 0: abort with hit

    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      t = $urandom_range(0, 255);
      if (r == 0) begin
        run_op(1, 0, 0);
      end else if (r == 1 && m_valid) begin
        drive_pos = $urandom_range(0, drive_pos);   // head slipped outward
        run_op(0, t, 0);
      end else if (r == 2) begin
        run_op(0, m_cur, 0);
      end else begin
        run_op(0, t, 0);
      end
    end

    // Reset while waiting on a 128-step chunk
    run_op(1, 0, 0);
    @(negedge clk);
    sif.cmd_start = 1'b1; sif.cmd_recal = 1'b0; sif.target_track = 8'd150;
    @(negedge clk);
    sif.cmd_start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", sif.busy, 0);
    check("rstmid_step_write", sif.step_write, 0);
    check("rstmid_track_valid", sif.track_valid, 0);
    check("rstmid_done", sif.done, 0);
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (sif.done === 1'b1 || sif.step_write === 1'b1) dn++;
    end
    check("rstmid_no_done_or_write", dn, 0);
    m_cur = 0; m_valid = 0;
    run_op(1, 0, 0);
    run_op(0, 77, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seek_sequencer.md
# seek_sequencer

Host-facing seek/recalibrate engine that sits directly upstream of the head step controller. It accepts "seek to track T" and "recalibrate" commands, tracks the current head cylinder, and breaks each move into step-controller control-byte writes of at most 128 steps. It interprets the track-0 hit status that comes back, then applies a head-settle delay before reporting completion.

## Interface
- SETTLE_CYCLES, 16'd20000: CLK cycles of head-settle delay after any move of at least one step.
- RECAL_STEPS, 9'd256: maximum outward steps a recalibrate issues before it declares failure (1..511).
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- CMD_START  in  1  one-cycle command strobe; ignored while BUSY=1.
- CMD_RECAL  in  1  sampled with CMD_START: 1 = recalibrate, 0 = seek.
- TARGET_TRACK  in  8  seek target, sampled with CMD_START.
- BUSY  out  1  high from the cycle after an accepted CMD_START until DONE.
- DONE  out  1  one-cycle completion pulse.
- ERROR  out  1  result flag, valid with DONE, held until the next accepted start.
- CUR_TRACK  out  8  current head cylinder.
- TRACK_VALID  out  1  CUR_TRACK is known.
- STEP_CTLBYTE  out  8  to the step controller: bit7 = direction (1 = out toward track 0), bits6:0 = count.
- STEP_WRITE  out  1  one-cycle write strobe to the step controller.
- STEP_BUSY  in  1  the step controller's stepping status.
- STEP_TRACK0_HIT  in  1  the step controller's track-0-hit status.

## Operation
- Step controller contract: count field N produces N+1 step pulses. The controller aborts before any pulse while the drive reports track 0 with direction out. STEP_BUSY rises on the cycle after STEP_WRITE. STEP_TRACK0_HIT is valid on the cycle after STEP_BUSY is first sampled low.
- Reset values:
  - BUSY=0, DONE=0, ERROR=0.
  - CUR_TRACK=0, TRACK_VALID=0.
  - STEP_CTLBYTE=0, STEP_WRITE=0.
  - State IDLE, internal remaining-step counter REM (9 bits) = 0.
- States and transitions:
  - IDLE: on CMD_START, latch the command and target and set ERROR=0, then go to CALC.
  - CALC, seek with TRACK_VALID=0: ERROR=1, go to FINISH. No steps are issued.
  - CALC, seek with TARGET==CUR_TRACK: go to FINISH with no settle.
  - CALC, other seeks: DIR = (TARGET<CUR_TRACK), REM = |TARGET-CUR_TRACK|.
  - CALC, recalibrate: DIR=1, REM=RECAL_STEPS, TRACK_VALID=0.
  - ISSUE: CHUNK = min(REM,128). Drive STEP_CTLBYTE={DIR, CHUNK-1} and STEP_WRITE=1 for exactly one cycle, then go to ACK.
  - ACK: one cycle, STEP_BUSY ignored, go to WAIT.
  - WAIT: stay until STEP_BUSY==0, then go to CHECK.
  - CHECK (samples STEP_TRACK0_HIT), recalibrate:
    - Hit: CUR_TRACK=0, TRACK_VALID=1, go to SETTLE.
    - No hit: REM-=CHUNK. Go to ISSUE if REM>0, else ERROR=1 and go to FINISH with TRACK_VALID still 0.
  - CHECK, seek:
    - Hit: CUR_TRACK=0. ERROR=1 if TARGET!=0. Go to SETTLE.
    - No hit: CUR_TRACK ±= CHUNK (minus when DIR=1), REM-=CHUNK. Go to ISSUE if REM>0, else SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then go to FINISH.
  - FINISH: DONE=1 for one cycle, BUSY=0, go to IDLE.
- Arithmetic: 9-bit unsigned difference, so no wrap. CUR_TRACK never wraps, because outward moves are bounded by the delta.
- RESET mid-operation aborts immediately to the reset values. No DONE is emitted. The step controller shares RESET.

## Timing
- An accepted start with TARGET==CUR_TRACK (valid) gives DONE 3 cycles after the start edge. No STEP_WRITE occurs.
- Write spacing: consecutive STEP_WRITE pulses are at least 4 cycles apart (ISSUE, ACK, WAIT≥1, CHECK).
- Settle: DONE follows the last CHECK by SETTLE_CYCLES+1 cycles.
- BUSY and DONE never overlap. BUSY falls on the edge where DONE rises.
- A CMD_START that coincides with DONE is ignored.

## Structure
- Shared package (disc_pkg): state encodings, DIR_OUT=1'b1, DIR_IN=1'b0, MAX_CHUNK=128.
- Sub-module settle_timer: 16-bit load/count-down, with a done pulse.

## Test plan
- Recal with the drive model asserting track 0 after 37 steps → exactly 1 write with byte 0xFF, hit reported, CUR_TRACK=0, TRACK_VALID=1, ERROR=0, DONE after settle.
- From track 0, seek to 200 → writes 0x7F then 0x47 (128+72 steps), CUR_TRACK=200, ERROR=0.
- From 200, seek to 5 → writes 0xFF then 0xC2 (128+67 out), CUR_TRACK=5.
- Recal, track 0 never asserted, RECAL_STEPS=256 → 2 writes of 0xFF, ERROR=1, TRACK_VALID=0.
- Seek after reset (TRACK_VALID=0) → no writes, DONE at +3 cycles, ERROR=1. Seek to the current track → no writes, ERROR=0.
- RESET asserted during WAIT of a 128-step seek → next cycle BUSY=0, STEP_WRITE=0, TRACK_VALID=0, no DONE pulse.
